// File: rtl/mnist_layer_sequencer.sv
// Run sequencer for the MNIST MLP accelerator: issues (image, layer) jobs to the
// shared layer engine, drains each image's class scores into the output buffer, then signals completion.
module mnist_layer_sequencer #(
  parameter int IMGNUM  = 10,
  parameter int NLAYER  = 3,
  parameter int NCLASS  = 10,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 4096,
  localparam int IW     = (IMGNUM > 1) ? $clog2(IMGNUM) : 1,
  localparam int LW     = $clog2(NLAYER) + 1
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_START,
  output logic          o_BUSY,
  output logic          o_ENG_START,
  output logic [IW-1:0] o_ENG_IMG,
  output logic [LW-1:0] o_ENG_LAYER,
  input  logic          i_ENG_DONE,
  input  logic          i_SCORE_VALID,
  input  logic [DW-1:0] i_SCORE_DATA,
  output logic          o_SCORE_READY,
  output logic          o_OUTBUF_WE,
  output logic [AW-1:0] o_OUTBUF_ADDR,
  output logic [DW-1:0] o_OUTBUF_DATA,
  output logic          o_IRQ_DONE,
  output logic          o_LED_DONE,
  output logic          o_ERR,
  output logic [2:0]    o_DBG_STATE
);

  localparam int KW  = (NCLASS > 1) ? $clog2(NCLASS) : 1;
  localparam int IXW = (IMGNUM * NCLASS > 1) ? $clog2(IMGNUM * NCLASS) : 1;
  localparam int WW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   img_q, img_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [KW-1:0]   k_q, k_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            led_q, led_d;
  logic            err_q, err_d;
  logic [IXW-1:0]  idx;

  // Score beat handshake: a beat transfers on any cycle where i_SCORE_VALID and
  // o_SCORE_READY are both high; ready is high only in DRAIN, valid may toggle freely.
  assign idx = IXW'(img_q) * IXW'(NCLASS) + IXW'(k_q);

  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    layer_d = layer_q;
    k_d     = k_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    led_d   = led_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_START) begin
          state_d = S_ISSUE;
          img_d   = '0;
          layer_d = '0;
          k_d     = '0;
          led_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle takes priority over the abort.
        if (i_ENG_DONE) begin
          if (layer_q == LW'(NLAYER - 1)) begin
            state_d = S_DRAIN;
            k_d     = '0;
          end else begin
            layer_d = layer_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (TIMEOUT != 0) begin
          if (wd_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (i_SCORE_VALID) begin
          we_d   = 1'b1;
          addr_d = AW'({idx, 2'b00});
          data_d = i_SCORE_DATA;
          if (k_q == KW'(NCLASS - 1)) begin
            k_d     = '0;
            state_d = S_FLUSH;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (img_q != IW'(IMGNUM - 1)) begin
          img_d   = img_q + 1'b1;
          layer_d = '0;
          state_d = S_ISSUE;
        end else begin
          led_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      img_q   <= '0;
      layer_q <= '0;
      k_q     <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      img_q   <= img_d;
      layer_q <= layer_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  assign o_BUSY        = (state_q != S_IDLE);
  assign o_ENG_START   = (state_q == S_ISSUE);
  assign o_ENG_IMG     = img_q;
  assign o_ENG_LAYER   = layer_q;
  assign o_SCORE_READY = (state_q == S_DRAIN);
  assign o_OUTBUF_WE   = we_q;
  assign o_OUTBUF_ADDR = addr_q;
  assign o_OUTBUF_DATA = data_q;
  assign o_IRQ_DONE    = (state_q == S_DONE);
  assign o_LED_DONE    = led_q;
  assign o_ERR         = err_q;
  assign o_DBG_STATE   = state_q;

endmodule

// File: doc/mnist_layer_sequencer.md
# mnist_layer_sequencer

Top-level sequencer for the MNIST MLP accelerator. It steps the shared layer-compute engine through every (image, layer) pair with a start/done handshake. After each image's last layer it drains the engine's class-score stream into the output buffer at byte addresses. It then raises the done interrupt and LED, and it aborts cleanly on an engine timeout.

## Interface
- IMGNUM, 10, number of images per run
- NLAYER, 3, layers per image (≥1)
- NCLASS, 10, scores per image
- DW, 32, score/output data width
- AW, 32, output-buffer byte-address width
- TIMEOUT, 4096, max cycles waiting for engine done; 0 disables the watchdog
- i_CLK  in  1  clock; all logic on the rising edge
- i_RST  in  1  synchronous, active-high reset
- i_START  in  1  run request; sampled only in IDLE
- o_BUSY  out  1  high in every state except IDLE
- o_ENG_START  out  1  one-cycle engine start pulse
- o_ENG_IMG  out  $clog2(IMGNUM)  image index; held stable from ISSUE through the end of WAIT
- o_ENG_LAYER  out  $clog2(NLAYER)+1  layer index; same stability rule as o_ENG_IMG
- i_ENG_DONE  in  1  engine completion pulse
- i_SCORE_VALID  in  1  score beat valid
- i_SCORE_DATA  in  DW  score value
- o_SCORE_READY  out  1  sequencer accepts a score beat
- o_OUTBUF_WE  out  1  output-buffer write enable
- o_OUTBUF_ADDR  out  AW  byte address = (img*NCLASS+k)<<2, zero-extended
- o_OUTBUF_DATA  out  DW  write data
- o_IRQ_DONE  out  1  one-cycle pulse at end of run (normal or aborted)
- o_LED_DONE  out  1  set on normal completion; cleared by accepted start or reset
- o_ERR  out  1  sticky timeout flag; cleared by accepted start or reset

## Operation
- **States:** IDLE, ISSUE, WAIT, DRAIN, FLUSH, DONE.
- **IDLE**
  - On i_START: go to ISSUE with img=0 and layer=0.
  - Accepting a start clears o_LED_DONE and o_ERR.
- **ISSUE:** o_ENG_START=1 for exactly this cycle, clear the watchdog counter, go to WAIT.
- **WAIT**
  - On i_ENG_DONE with layer<NLAYER-1: layer++, go to ISSUE.
  - On i_ENG_DONE with layer=NLAYER-1: go to DRAIN with k=0.
  - Otherwise the watchdog counts once per cycle. When the count reaches TIMEOUT with no done (TIMEOUT≠0): set o_ERR and go to DONE as an abort.
  - If done and the timeout expiry fall in the same cycle, done wins.
- **DRAIN**
  - o_SCORE_READY=1.
  - Each handshake (valid&ready) registers one write: WE=1 on the next cycle, ADDR=((img*NCLASS+k)<<2), DATA=i_SCORE_DATA. k then increments.
  - On the NCLASS-th handshake: ready drops the next cycle, go to FLUSH.
- **FLUSH:** the last write is visible this cycle.
  - If img<IMGNUM-1: img++, layer=0, go to ISSUE.
  - Otherwise go to DONE.
- **DONE**
  - o_IRQ_DONE=1 for one cycle.
  - o_LED_DONE is set unless this is an abort.
  - Then go to IDLE.
- **Ignored inputs:**
  - i_START outside IDLE.
  - i_ENG_DONE outside WAIT.
  - i_SCORE_VALID outside DRAIN (ready is low there).
- No watchdog runs in DRAIN. A stalled score stream holds the sequencer in DRAIN indefinitely.
- Address arithmetic uses an img*NCLASS+k index of $clog2(IMGNUM*NCLASS) bits. The maximum byte address is (IMGNUM*NCLASS-1)*4, which is 396 for the defaults.

## Timing
- **Reset:**
  - State IDLE; img, layer, k and the watchdog all 0.
  - All outputs 0, including o_OUTBUF_ADDR and o_OUTBUF_DATA.
  - Reset mid-run aborts immediately with no IRQ and no further writes.
- Start accepted at cycle t → o_BUSY=1 and o_ENG_START=1 at t+1.
- i_ENG_DONE at cycle d (not the last layer) → o_ENG_START=1 at d+1 with the incremented layer.
- i_ENG_DONE at d (last layer) → o_SCORE_READY=1 from d+1.
- Handshake at cycle h → o_OUTBUF_WE=1 at h+1. Back-to-back beats give back-to-back writes.
- **End of image:**
  - Final handshake at b → last write at b+1 (FLUSH).
  - Next image: o_ENG_START at b+2.
  - Final image: o_IRQ_DONE at b+2 (DONE); IDLE and o_BUSY=0 at b+3.
- Timeout: o_ERR and o_IRQ_DONE both rise TIMEOUT+1 cycles after the ISSUE cycle (ERR in DONE, registered), then IDLE.
- A new start is accepted in the first IDLE cycle after DONE.

## Test plan
- **Normal run** (IMGNUM=2, NLAYER=3, engine done 5 cycles after each start; scores 0x100+k streamed back-to-back):
  - 6 start pulses, in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - 20 writes at addresses 0x00..0x4C step 4, data 0x100..0x109 repeated.
  - One IRQ pulse; LED=1.
- **Back-pressure:** i_SCORE_VALID toggled 1-0-1-0 → writes occur only on the cycle after each handshake, address increments only per beat, and no extra writes occur.
- **Spurious inputs:**
  - i_ENG_DONE while in DRAIN → ignored.
  - i_START while busy → ignored.
  - Data stream while in WAIT → o_SCORE_READY stays 0.
- **Timeout:** TIMEOUT=16, engine never answers → o_ERR=1 and IRQ pulse 17 cycles after o_ENG_START, LED=0, BUSY=0; a subsequent start clears o_ERR.
- **Reset mid-DRAIN** after 4 beats → all outputs 0 on the next cycle, no IRQ; a fresh start restarts at img 0 with address 0x00.
- **Done/timeout collision:** i_ENG_DONE on the expiry cycle → the run continues normally and o_ERR stays 0.
